// File: rtl/polar_clip_sat_out.sv
// Rounds and saturates signed multiplier products to 16 bits, buffers them in a credit-managed FIFO and
// streams them out framed. Define POLAR_CLIP_SAT_STATUS_EN to add the sat_count status output.
module polar_clip_sat_out #(
  parameter int SHIFT     = 15,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        issue,
  output logic        issue_ok,
  input  logic        prod_valid,
  input  logic [31:0] prod_data,
  output logic [15:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
`ifdef POLAR_CLIP_SAT_STATUS_EN
  output logic [15:0] sat_count,
`endif
  output logic        err_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_X = {1'b0, DEPTH_C};
  localparam logic [15:0]   LAST_BEAT = 16'(FRAME_LEN - 1);
  localparam logic signed [32:0] HALF = 33'sd1 <<< (SHIFT - 1);
  localparam logic signed [32:0] SAT_HI = 33'sd32767;
  localparam logic signed [32:0] SAT_LO = -33'sd32768;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [15:0]   beat_q, beat_d;
  logic          err_q;

  logic signed [32:0] prod_ext_s, rounded_s, shifted_s;
  logic [15:0]        result_s;
  logic               sat_hit_s;
  logic               pop_s, push_s, full_s, issue_acc_s;

  assign prod_ext_s = {prod_data[31], prod_data};
  assign rounded_s  = prod_ext_s + HALF;
  assign shifted_s  = rounded_s >>> SHIFT;

  // Clip the rounded value into the 16-bit signed range.
  always_comb begin
    result_s  = shifted_s[15:0];
    sat_hit_s = 1'b0;
    if (shifted_s > SAT_HI) begin
      result_s  = 16'h7FFF;
      sat_hit_s = 1'b1;
    end else if (shifted_s < SAT_LO) begin
      result_s  = 16'h8000;
      sat_hit_s = 1'b1;
    end else begin
      result_s  = shifted_s[15:0];
      sat_hit_s = 1'b0;
    end
  end

  assign full_s      = (count_q == DEPTH_C);
  assign m_tvalid    = (count_q != {CW{1'b0}});
  assign pop_s       = m_tvalid && m_tready;
  assign push_s      = prod_valid && (!full_s || pop_s);
  assign issue_ok    = ({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_X;
  assign issue_acc_s = issue && issue_ok;
  assign m_tdata     = m_tvalid ? mem_q[rd_ptr_q] : 16'h0000;
  assign m_tlast     = m_tvalid && (beat_q == LAST_BEAT);
  assign err_ovf     = err_q;

  // Next-state for occupancy, outstanding multiplier credits and frame position.
  always_comb begin
    count_d    = count_q;
    inflight_d = inflight_q;
    beat_d     = beat_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case ({issue_acc_s, prod_valid})
      2'b10:   inflight_d = (inflight_q < DEPTH_C) ? inflight_q + CW'(1) : inflight_q;
      2'b01:   inflight_d = (inflight_q != {CW{1'b0}}) ? inflight_q - CW'(1) : inflight_q;
      default: inflight_d = inflight_q;
    endcase
    if (pop_s) begin
      beat_d = (beat_q == LAST_BEAT) ? 16'h0000 : beat_q + 16'h0001;
    end else begin
      beat_d = beat_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= {CW{1'b0}};
      inflight_q <= {CW{1'b0}};
      beat_q     <= 16'h0000;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      err_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (prod_valid && full_s && !pop_s) err_q <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= result_s;
  end

`ifdef POLAR_CLIP_SAT_STATUS_EN
  logic [15:0] sat_cnt_q;
  assign sat_count = sat_cnt_q;

  // Count every clipped product, sticking at the top value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_cnt_q <= 16'h0000;
    end else if (prod_valid && sat_hit_s && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_polar_clip_sat_out.sv
// Scoreboard bench for polar_clip_sat_out (DEPTH=8, FRAME_LEN=4, SHIFT=15) with hand-computed vectors.
module tb_polar_clip_sat_out;

  localparam int DEPTH = 8;
  localparam int FLEN  = 4;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue = 1'b0;
  logic        issue_ok;
  logic        prod_valid = 1'b0;
  logic [31:0] prod_data = 32'h0;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        err_ovf;
`ifdef POLAR_CLIP_SAT_STATUS_EN
  logic [15:0] sat_count;
`endif

  int   tests = 0;
  int   fails = 0;
  int   beat_idx = 0;
  exp_t sbq[$];

  polar_clip_sat_out #(.SHIFT(15), .DEPTH(DEPTH), .FRAME_LEN(FLEN)) dut (
    .clk(clk), .reset_n(reset_n), .issue(issue), .issue_ok(issue_ok),
    .prod_valid(prod_valid), .prod_data(prod_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
`ifdef POLAR_CLIP_SAT_STATUS_EN
    .sat_count(sat_count),
`endif
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] p, input logic [15:0] e, input bit acc);
    prod_valid = 1'b1;
    prod_data  = p;
    if (acc) begin
      sbq.push_back(exp_t'{data: e, last: (beat_idx == FLEN - 1)});
      beat_idx = (beat_idx + 1) % FLEN;
    end
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sbq.size() != 0 || m_tvalid) && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(sbq.size()), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
    check({tag, "_tlast"}, 32'(m_tlast), 32'd0);
    check({tag, "_tdata"}, 32'(m_tdata), 32'd0);
    check({tag, "_issue_ok"}, 32'(issue_ok), 32'd1);
    check({tag, "_err_ovf"}, 32'(err_ovf), 32'd0);
  endtask

  // Monitor: every presented beat must match the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (reset_n && m_tvalid) begin
      if (sbq.size() == 0) begin
        check("unexpected_beat", 32'(m_tdata), 32'hDEAD);
      end else begin
        check("beat_data", 32'(m_tdata), 32'(sbq[0].data));
        check("beat_last", 32'(m_tlast), 32'(sbq[0].last));
        if (m_tready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int sent;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check_idle("reset");

    // Rounding / saturation with the sink always ready.
    m_tready = 1'b1;
    send(32'h0000_4000, 16'h0001, 1'b1);
    send(32'h0000_3FFF, 16'h0000, 1'b1);
    send(32'h4000_0000, 16'h7FFF, 1'b1);
    send(32'hC000_8000, 16'h8001, 1'b1);
    send(32'hFFFF_8000, 16'hFFFF, 1'b1);
    send(32'hFFFF_C000, 16'h0000, 1'b1);
    send(32'h8000_0000, 16'h8000, 1'b1);
    wait_drain("round_drain");
`ifdef POLAR_CLIP_SAT_STATUS_EN
    check("sat_count", 32'(sat_count), 32'd2);
`endif

    // Credit flow: issue continuously with the sink stalled.
    m_tready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      issue = 1'b1;
      if (issue_ok) acc++;
      tick();
    end
    issue = 1'b0;
    check("credit_accepted", 32'(acc), 32'(DEPTH));
    check("credit_issue_ok_low", 32'(issue_ok), 32'd0);
    for (int k = 1; k <= DEPTH; k++) send(32'(k) << 15, 16'(k), 1'b1);
    check("credit_no_ovf", 32'(err_ovf), 32'd0);
    check("credit_full_issue_ok", 32'(issue_ok), 32'd0);
    m_tready = 1'b1;
    wait_drain("credit_drain");
    check("credit_issue_ok_back", 32'(issue_ok), 32'd1);

    // Push and pop together while full.
    m_tready = 1'b0;
    for (int k = 0; k < DEPTH; k++) send(32'(k + 20) << 15, 16'(k + 20), 1'b1);
    m_tready = 1'b1;
    send(32'h0010_0000, 16'h0020, 1'b1);
    m_tready = 1'b0;
    check("pushpop_still_full", 32'(issue_ok), 32'd0);
    check("pushpop_no_ovf", 32'(err_ovf), 32'd0);
    m_tready = 1'b1;
    wait_drain("pushpop_drain");

    // Forced overflow: ninth product is dropped.
    m_tready = 1'b0;
    for (int k = 0; k < DEPTH; k++) send(32'(k + 40) << 15, 16'(k + 40), 1'b1);
    check("ovf_before", 32'(err_ovf), 32'd0);
    send(32'h7FFF_0000, 16'h7FFF, 1'b0);
    check("ovf_set", 32'(err_ovf), 32'd1);
    m_tready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_sticky", 32'(err_ovf), 32'd1);

    // Reset mid-stream with 5 queued and 2 products still in the multiplier.
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) send(32'(k + 60) << 15, 16'(k + 60), 1'b1);
    issue = 1'b1;
    tick();
    tick();
    issue = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_async_tvalid", 32'(m_tvalid), 32'd0);
    sbq.delete();
    beat_idx = 0;
    tick();
    reset_n = 1'b1;
    tick();
    check_idle("rst_mid");

    // Framing: drained products plus 8 more, random stalls.
    send(32'h0000_8000, 16'h0001, 1'b1);
    send(32'h0001_0000, 16'h0002, 1'b1);
    check("drain_issue_ok", 32'(issue_ok), 32'd1);
    sent = 0;
    for (int c = 0; c < 300 && sent < 8; c++) begin
      m_tready = 1'($urandom_range(0, 1));
      if (sbq.size() < 6) begin
        send(32'(sent + 3) << 15, 16'(sent + 3), 1'b1);
        sent++;
      end else begin
        tick();
      end
    end
    check("frame_sent", 32'(sent), 32'd8);
    for (int c = 0; c < 40; c++) begin
      m_tready = 1'($urandom_range(0, 1));
      tick();
    end
    m_tready = 1'b1;
    wait_drain("frame_drain");
    check("frame_end_tlast", 32'(m_tlast), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/polar_clip_sat_out.md
POLAR_CLIP_SAT_OUT -- requirements
Module: polar_clip_sat_out

Interface
REQ-001 SHALL have parameter SHIFT, default 15: arithmetic right-shift applied to the product, legal range 1..16.
REQ-002 SHALL have parameter DEPTH, default 8: output FIFO entries, power of two, 4..16.
REQ-003 SHALL have parameter FRAME_LEN, default 64: output beats per frame, 2..65535.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port issue, input, 1: upstream launched one operand pair into the 4-stage multiplier this cycle.
REQ-007 SHALL have port issue_ok, output, 1: upstream may assert issue this cycle.
REQ-008 SHALL have port prod_valid, input, 1: prod_data holds a finished product this cycle.
REQ-009 SHALL have port prod_data, input, 32: signed multiplier product.
REQ-010 SHALL have ports m_tdata (output, 16, signed result), m_tvalid (output, 1), m_tready (input, 1) and m_tlast (output, 1, last beat of frame).
REQ-011 SHALL have port err_ovf, output, 1: sticky flag, product arrived while FIFO full.

Function
REQ-012 SHALL compute r = (prod_data + 2^(SHIFT-1)) >>> SHIFT in 33-bit signed arithmetic, i.e. round half toward +infinity.
REQ-013 SHALL saturate r to [-32768, 32767] before writing it to the FIFO.
REQ-014 SHALL write one FIFO entry per prod_valid cycle when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-015 SHALL drop the product and set err_ovf when prod_valid arrives with the FIFO full and no pop in that cycle; err_ovf clears only on reset.
REQ-016 SHALL drive m_tvalid = (count != 0), with m_tdata equal to the head entry; a beat completes when m_tvalid && m_tready.
REQ-017 SHALL give a latency of 1 cycle: with the FIFO empty, a product on cycle N appears on m_tdata/m_tvalid on cycle N+1.
REQ-018 SHALL keep m_tdata and m_tlast stable while m_tvalid && !m_tready.
REQ-019 SHALL keep an inflight counter: +1 on issue, -1 on prod_valid, unchanged when both occur; it saturates at 0 and at DEPTH.
REQ-020 SHALL drive issue_ok = (count + inflight) < DEPTH, combinational from registered state only.
REQ-021 SHALL ignore issue asserted while issue_ok is low; inflight does not increment.
REQ-022 SHALL keep a beat counter 0..FRAME_LEN-1 that increments per completed beat and wraps to 0 after FRAME_LEN-1.
REQ-023 SHALL assert m_tlast with m_tvalid when the beat counter equals FRAME_LEN-1.
REQ-024 SHALL handle FIFO pointer wrap-around modulo DEPTH, with full/empty decided by the count register.

Reset
REQ-025 SHALL, on reset_n low, asynchronously clear count, pointers, inflight, beat counter and err_ovf; m_tvalid=0, m_tlast=0, m_tdata=0, issue_ok=1 after deassertion.
REQ-026 SHALL, after a reset taken mid-operation, accept products still draining from the multiplier (inflight stays 0 per REQ-019), FIFO space permitting.

Configuration
REQ-027 SHALL, with macro POLAR_CLIP_SAT_STATUS_EN defined, add output sat_count (16 bits), counting saturated results, stopping at 65535, cleared by reset.
REQ-028 SHALL, without POLAR_CLIP_SAT_STATUS_EN, omit the sat_count port and its logic; all other behaviour is identical.

Verification
REQ-029 SHALL verify rounding and saturation (SHIFT=15, m_tready=1): prod_data 0x00004000 -> 1; 0x00003FFF -> 0; 0x40000000 -> 32767 (saturated); 0xC0008000 -> -32767 (0x8001).
REQ-030 SHALL verify credit flow control: hold m_tready=0 and issue every cycle while issue_ok -> exactly DEPTH issues accepted, issue_ok low, err_ovf stays 0, and all 8 results drain in order once m_tready=1.
REQ-031 SHALL verify forced overflow: 9 products with no issue and m_tready=0 -> 9th dropped, err_ovf=1, FIFO holds the first 8.
REQ-032 SHALL verify framing (FRAME_LEN=4): 10 beats with random m_tready stalls -> m_tlast on beats 4 and 8 only, data stable during stalls.
REQ-033 SHALL verify reset mid-stream: assert reset_n low with 5 entries queued -> m_tvalid=0 immediately; after release, issue_ok=1 and beat counter restarts at 0.
REQ-034 SHALL verify simultaneous push and pop with the FIFO full -> count stays DEPTH and no err_ovf; with POLAR_CLIP_SAT_STATUS_EN, sat_count=1 after the 0x40000000 case.
